// File: rtl/pcie_phy_pkg.sv
// pcie_phy_pkg
// Shared types and helpers for the PHY transmit unpacker.
//   unpack_st_e      : unpacker FSM state encoding.
//   PipeWidthGen1..5 : PIPE data widths (bits) used per PCIe generation.
//   chunks_per_word  : number of PIPE beats needed to emit one lane word.
//   chunk_bits       : width in bits of a single beat for a given chunk count.
package pcie_phy_pkg;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_STREAM = 1'b1
    } unpack_st_e;

    localparam logic [5:0] PipeWidthGen1 = 6'd8;
    localparam logic [5:0] PipeWidthGen2 = 6'd16;
    localparam logic [5:0] PipeWidthGen3 = 6'd32;
    localparam logic [5:0] PipeWidthGen4 = 6'd32;
    localparam logic [5:0] PipeWidthGen5 = 6'd32;

    // Unsupported widths, or widths wider than a lane word, fall back to
    // emitting the whole lane word in a single beat.
    function automatic logic [2:0] chunks_per_word(input logic [5:0] pipe_width,
                                                   input int unsigned data_width);
        logic [2:0] chunks;
        chunks = 3'd1;
        if (32'(pipe_width) <= data_width) begin
            case (pipe_width)
                6'd8:    chunks = 3'(data_width / 8);
                6'd16:   chunks = 3'(data_width / 16);
                6'd32:   chunks = 3'(data_width / 32);
                default: chunks = 3'd1;
            endcase
        end
        return chunks;
    endfunction

    function automatic int unsigned chunk_bits(input logic [2:0] chunks,
                                               input int unsigned data_width);
        int unsigned bits;
        case (chunks)
            3'd2:    bits = data_width / 2;
            3'd4:    bits = data_width / 4;
            default: bits = data_width;
        endcase
        return bits;
    endfunction

endpackage

// File: rtl/unpack_lane_slice.sv
// unpack_lane_slice
// Combinational selector for one lane: picks beat chunk_idx_i out of the
// buffered lane word and its K flags, low-aligned with upper bits zeroed.
// Ports:
//   lane_data_i  : buffered lane word (DATA_WIDTH bits).
//   lane_k_i     : buffered K flags for the lane, one per byte.
//   lane_en_i    : lane is streaming and active; output is zero otherwise.
//   chunk_idx_i  : beat index within the word.
//   chunks_i     : beats per word (1, 2 or 4).
//   data_o/k_o   : selected beat data and K flags.
module unpack_lane_slice
    import pcie_phy_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] lane_data_i,
    input  logic [3:0]            lane_k_i,
    input  logic                  lane_en_i,
    input  logic [1:0]            chunk_idx_i,
    input  logic [2:0]            chunks_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic [3:0]            k_o
);

    localparam logic [DATA_WIDTH-1:0] AllOnes = '1;

    int unsigned     cw;
    int unsigned     kb;
    logic [DATA_WIDTH-1:0] data_mask;
    logic [3:0]      k_mask;

    always_comb begin
        cw        = chunk_bits(chunks_i, DATA_WIDTH);
        kb        = cw / 8;
        data_mask = AllOnes >> (DATA_WIDTH - cw);
        k_mask    = 4'hF >> (4 - kb);
        data_o    = '0;
        k_o       = '0;
        if (lane_en_i) begin
            data_o = (lane_data_i >> (32'(chunk_idx_i) * cw)) & data_mask;
            k_o    = (lane_k_i >> (32'(chunk_idx_i) * kb)) & k_mask;
        end
    end

endmodule

// File: rtl/unpack_data.sv
// unpack_data
// Serialises one wide per-lane word from the TX FIFO onto the PIPE TX lanes,
// pipe_width_i bits per lane per clock, least-significant chunk first.
// Ports:
//   clk_i, rst_ni            : clock, asynchronous active-low reset.
//   phy_link_up_i            : low aborts the current word and blocks input.
//   lane_reverse_i           : reverse logical lane order (only honoured when
//                              UNPACK_LANE_REVERSE_EN is defined).
//   pipe_width_i             : PIPE width 8/16/32, sampled at handshake.
//   num_active_lanes_i       : active lanes, sampled at handshake (0 -> 1).
//   word_valid_i/word_ready_o, data_i, data_k_i, sync_header_i : input word.
//   data_o, data_k_o, data_valid_o, sync_header_o, start_block_o : PIPE TX.
//   dbg_state_o              : current FSM state for observation.
// Configuration macro: UNPACK_LANE_REVERSE_EN.
//
// Handshake: a word transfers on a rising clk_i edge where word_valid_i and
// word_ready_o are both high. word_ready_o is combinational and does not
// depend on word_valid_i; it is high when the link is up and the unit is idle
// or presenting the last chunk of the current word, which lets the next word
// follow with no bubble.
module unpack_data
    import pcie_phy_pkg::*;
#(
    parameter int DATA_WIDTH    = 32,
    parameter int MAX_NUM_LANES = 16
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic                                phy_link_up_i,
    input  logic                                lane_reverse_i,
    input  logic [5:0]                          pipe_width_i,
    input  logic [5:0]                          num_active_lanes_i,
    input  logic                                word_valid_i,
    output logic                                word_ready_o,
    input  logic [MAX_NUM_LANES*DATA_WIDTH-1:0] data_i,
    input  logic [4*MAX_NUM_LANES-1:0]          data_k_i,
    input  logic [2*MAX_NUM_LANES-1:0]          sync_header_i,
    output logic [MAX_NUM_LANES*DATA_WIDTH-1:0] data_o,
    output logic [4*MAX_NUM_LANES-1:0]          data_k_o,
    output logic [MAX_NUM_LANES-1:0]            data_valid_o,
    output logic [2*MAX_NUM_LANES-1:0]          sync_header_o,
    output logic                                start_block_o,
    output unpack_st_e                          dbg_state_o
);

    unpack_st_e st_q, st_d;
    logic [1:0] chunk_idx_q, chunk_idx_d;
    logic [2:0] chunks_q, chunks_d;
    logic [MAX_NUM_LANES*DATA_WIDTH-1:0] buf_q, buf_d;
    logic [4*MAX_NUM_LANES-1:0]          buf_k_q, buf_k_d;
    logic [2*MAX_NUM_LANES-1:0]          sh_q, sh_d;
    logic [MAX_NUM_LANES-1:0]            lane_en_q, lane_en_d;

    logic [1:0] last_idx;
    logic       handshake;
    logic       load;
    logic       rev;
    logic [5:0] n_lanes;
    logic       streaming;
    logic       beat0;

`ifdef UNPACK_LANE_REVERSE_EN
    assign rev = lane_reverse_i;
`else
    logic unused_lane_reverse;
    assign unused_lane_reverse = lane_reverse_i;
    assign rev = 1'b0;
`endif

    always_comb begin
        case (chunks_q)
            3'd4:    last_idx = 2'd3;
            3'd2:    last_idx = 2'd1;
            default: last_idx = 2'd0;
        endcase
    end

    assign word_ready_o = phy_link_up_i && (st_q == ST_IDLE || chunk_idx_q == last_idx);
    assign handshake    = word_valid_i && word_ready_o;
    assign chunks_d     = chunks_per_word(pipe_width_i, DATA_WIDTH);

    // Lane reversal is applied while loading, so the buffer always holds the
    // output lane order and the per-lane slices stay identity-mapped.
    // Inactive lanes are loaded as zero.
    always_comb begin : load_comb
        int src;
        n_lanes = num_active_lanes_i;
        if (n_lanes == 6'd0) begin
            n_lanes = 6'd1;
        end else if (n_lanes > 6'(MAX_NUM_LANES)) begin
            n_lanes = 6'(MAX_NUM_LANES);
        end
        buf_d     = '0;
        buf_k_d   = '0;
        sh_d      = '0;
        lane_en_d = '0;
        src       = 0;
        for (int l = 0; l < MAX_NUM_LANES; l++) begin
            if (l < int'(n_lanes)) begin
                src = rev ? (int'(n_lanes) - 1 - l) : l;
                buf_d[l*DATA_WIDTH +: DATA_WIDTH] = data_i[src*DATA_WIDTH +: DATA_WIDTH];
                buf_k_d[4*l +: 4] = data_k_i[4*src +: 4];
                sh_d[2*l +: 2]    = sync_header_i[2*src +: 2];
                lane_en_d[l]      = 1'b1;
            end
        end
    end

    always_comb begin : fsm_comb
        st_d        = st_q;
        chunk_idx_d = chunk_idx_q;
        load        = 1'b0;
        if (!phy_link_up_i) begin
            st_d        = ST_IDLE;
            chunk_idx_d = 2'd0;
        end else if (handshake) begin
            st_d        = ST_STREAM;
            chunk_idx_d = 2'd0;
            load        = 1'b1;
        end else if (st_q == ST_STREAM) begin
            if (chunk_idx_q != last_idx) begin
                chunk_idx_d = chunk_idx_q + 2'd1;
            end else begin
                st_d        = ST_IDLE;
                chunk_idx_d = 2'd0;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            st_q        <= ST_IDLE;
            chunk_idx_q <= 2'd0;
            chunks_q    <= 3'd1;
            buf_q       <= '0;
            buf_k_q     <= '0;
            sh_q        <= '0;
            lane_en_q   <= '0;
        end else begin
            st_q        <= st_d;
            chunk_idx_q <= chunk_idx_d;
            if (load) begin
                chunks_q  <= chunks_d;
                buf_q     <= buf_d;
                buf_k_q   <= buf_k_d;
                sh_q      <= sh_d;
                lane_en_q <= lane_en_d;
            end else if (!phy_link_up_i) begin
                // Link loss discards the buffered word.
                lane_en_q <= '0;
            end
        end
    end

    assign streaming     = (st_q == ST_STREAM);
    assign beat0         = streaming && (chunk_idx_q == 2'd0);
    assign start_block_o = beat0;
    assign dbg_state_o   = st_q;

    for (genvar g = 0; g < MAX_NUM_LANES; g++) begin : g_lane
        unpack_lane_slice #(
            .DATA_WIDTH(DATA_WIDTH)
        ) u_slice (
            .lane_data_i (buf_q[g*DATA_WIDTH +: DATA_WIDTH]),
            .lane_k_i    (buf_k_q[4*g +: 4]),
            .lane_en_i   (streaming && lane_en_q[g]),
            .chunk_idx_i (chunk_idx_q),
            .chunks_i    (chunks_q),
            .data_o      (data_o[g*DATA_WIDTH +: DATA_WIDTH]),
            .k_o         (data_k_o[4*g +: 4])
        );
        assign data_valid_o[g]       = streaming && lane_en_q[g];
        assign sync_header_o[2*g +: 2] = (beat0 && lane_en_q[g]) ? sh_q[2*g +: 2] : 2'b00;
    end

endmodule
